// File: rtl/rr_fifo_write_scheduler.sv
// Round-robin arbiter sharing one FIFO write port among several busy/request writers,
// with FIFO-full backpressure, a per-writer enable mask and rotating priority.
module rr_fifo_write_scheduler #(
    parameter int NUM_WRITERS = 4,
    parameter int DATA_W      = 8
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_WRITERS*DATA_W-1:0]   i_data,
    input  logic [NUM_WRITERS-1:0]          i_req,
    input  logic [NUM_WRITERS-1:0]          i_enable,
    input  logic                            i_full,
    output logic [NUM_WRITERS-1:0]          o_busy,
    output logic [DATA_W-1:0]               o_data,
    output logic                            o_we,
    output logic [$clog2(NUM_WRITERS)-1:0]  o_grant_idx
);

    localparam int IDX_W = $clog2(NUM_WRITERS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_WRITERS-1:0] eligible;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic [DATA_W-1:0]  data_arr [NUM_WRITERS];

    assign eligible = i_req & i_enable;

    for (genvar g = 0; g < NUM_WRITERS; g++) begin : g_unpack
        assign data_arr[g] = i_data[g*DATA_W +: DATA_W];
    end

    // Search upward from rr_ptr with explicit wrap so non-power-of-2 counts stay in range
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 0; off < NUM_WRITERS; off++) begin
            if (int'(rr_ptr) + off >= NUM_WRITERS)
                cand = IDX_W'(int'(rr_ptr) + off - NUM_WRITERS);
            else
                cand = IDX_W'(int'(rr_ptr) + off);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            o_busy      <= '1;
            o_we        <= 1'b0;
            o_data      <= '0;
            o_grant_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_busy <= '1;
                    o_we   <= 1'b0;
                    if (found && !i_full) begin
                        o_busy[pick] <= 1'b0;
                        o_grant_idx  <= pick;
                        rr_ptr       <= (pick == IDX_W'(NUM_WRITERS-1)) ? '0 : pick + 1'b1;
                        state        <= GRANT;
                    end
                end
                // Data is captured even if the writer dropped its request meanwhile
                GRANT: begin
                    o_data <= data_arr[o_grant_idx];
                    o_we   <= 1'b1;
                    o_busy <= '1;
                    state  <= WRITE;
                end
                WRITE: begin
                    o_we  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    o_busy <= '1;
                    o_we   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_fifo_write_scheduler.sv
// Directed self-checking bench for rr_fifo_write_scheduler with NUM_WRITERS=4, DATA_W=8.
module tb_rr_fifo_write_scheduler;

    localparam int NW = 4;
    localparam int DW = 8;

    logic              i_clk;
    logic              i_reset_n;
    logic [NW*DW-1:0]  i_data;
    logic [NW-1:0]     i_req;
    logic [NW-1:0]     i_enable;
    logic              i_full;
    logic [NW-1:0]     o_busy;
    logic [DW-1:0]     o_data;
    logic              o_we;
    logic [1:0]        o_grant_idx;

    int n_cmp;
    int n_fail;

    rr_fifo_write_scheduler #(.NUM_WRITERS(NW), .DATA_W(DW)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_data      (i_data),
        .i_req       (i_req),
        .i_enable    (i_enable),
        .i_full      (i_full),
        .o_busy      (o_busy),
        .o_data      (o_data),
        .o_we        (o_we),
        .o_grant_idx (o_grant_idx)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic reset_dut();
        i_req     = '0;
        i_full    = 1'b0;
        i_enable  = '1;
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        n_cmp++;
        if (o_busy !== 4'b1111) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 1111", o_busy); end
        n_cmp++;
        if (o_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we got %b want 0", o_we); end
        n_cmp++;
        if (o_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data got %h want 00", o_data); end
        n_cmp++;
        if (o_grant_idx !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_idx got %0d want 0", o_grant_idx); end
    endtask

    task automatic test_single();
        i_data[1*DW +: DW] = 8'h5A;
        i_req = 4'b0010;
        tick();
        n_cmp++;
        if (o_busy !== 4'b1101) begin n_fail++; $display("[TB] FAIL single_busy got %b want 1101", o_busy); end
        n_cmp++;
        if (o_grant_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL single_idx got %0d want 1", o_grant_idx); end
        n_cmp++;
        if (o_we !== 1'b0) begin n_fail++; $display("[TB] FAIL single_we_early got %b want 0", o_we); end
        i_req = 4'b0000;
        tick();
        n_cmp++;
        if (o_we !== 1'b1 || o_data !== 8'h5A) begin
            n_fail++; $display("[TB] FAIL single_write got we=%b data=%h want we=1 data=5a", o_we, o_data);
        end
        n_cmp++;
        if (o_busy !== 4'b1111) begin n_fail++; $display("[TB] FAIL single_busy_back got %b want 1111", o_busy); end
        tick();
        n_cmp++;
        if (o_we !== 1'b0) begin n_fail++; $display("[TB] FAIL single_we_drop got %b want 0", o_we); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_data [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        int            exp_idx  [5] = '{0, 1, 2, 3, 0};
        logic [NW-1:0] exp_busy;
        reset_dut();
        for (int k = 0; k < NW; k++) i_data[k*DW +: DW] = DW'(8'h10 + k);
        i_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            exp_busy = 4'b1111;
            exp_busy[exp_idx[g]] = 1'b0;
            n_cmp++;
            if (o_busy !== exp_busy || o_grant_idx !== 2'(exp_idx[g])) begin
                n_fail++;
                $display("[TB] FAIL rr_grant%0d got busy=%b idx=%0d want busy=%b idx=%0d",
                         g, o_busy, o_grant_idx, exp_busy, exp_idx[g]);
            end
            tick();
            n_cmp++;
            if (o_we !== 1'b1 || o_data !== exp_data[g]) begin
                n_fail++;
                $display("[TB] FAIL rr_write%0d got we=%b data=%h want we=1 data=%h", g, o_we, o_data, exp_data[g]);
            end
            tick();
            n_cmp++;
            if (o_we !== 1'b0 || o_busy !== 4'b1111) begin
                n_fail++;
                $display("[TB] FAIL rr_gap%0d got we=%b busy=%b want we=0 busy=1111", g, o_we, o_busy);
            end
        end
        i_req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        reset_dut();
        i_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        i_req = 4'b0100;
        tick();
        n_cmp++;
        if (o_busy !== 4'b1011) begin n_fail++; $display("[TB] FAIL wrap_first got %b want 1011", o_busy); end
        i_req = 4'b1001;
        tick();
        tick();
        tick();
        n_cmp++;
        if (o_busy !== 4'b0111 || o_grant_idx !== 2'd3) begin
            n_fail++; $display("[TB] FAIL wrap_w3 got busy=%b idx=%0d want busy=0111 idx=3", o_busy, o_grant_idx);
        end
        i_req = 4'b0001;
        tick();
        n_cmp++;
        if (o_data !== 8'hD3) begin n_fail++; $display("[TB] FAIL wrap_w3_data got %h want d3", o_data); end
        tick();
        tick();
        n_cmp++;
        if (o_busy !== 4'b1110 || o_grant_idx !== 2'd0) begin
            n_fail++; $display("[TB] FAIL wrap_w0 got busy=%b idx=%0d want busy=1110 idx=0", o_busy, o_grant_idx);
        end
        i_req = 4'b0000;
        tick();
        n_cmp++;
        if (o_data !== 8'hA0) begin n_fail++; $display("[TB] FAIL wrap_w0_data got %h want a0", o_data); end
        tick();
    endtask

    task automatic test_backpressure();
        reset_dut();
        i_data[2*DW +: DW] = 8'h77;
        i_full = 1'b1;
        i_req  = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (o_busy !== 4'b1111 || o_we !== 1'b0) begin
                n_fail++; $display("[TB] FAIL full_hold%0d got busy=%b we=%b want 1111/0", c, o_busy, o_we);
            end
        end
        i_full = 1'b0;
        tick();
        n_cmp++;
        if (o_busy !== 4'b1011) begin n_fail++; $display("[TB] FAIL full_release got %b want 1011", o_busy); end
        i_req  = 4'b0000;
        i_full = 1'b1;
        tick();
        n_cmp++;
        if (o_we !== 1'b1 || o_data !== 8'h77) begin
            n_fail++; $display("[TB] FAIL full_in_grant got we=%b data=%h want we=1 data=77", o_we, o_data);
        end
        i_full = 1'b0;
        tick();
    endtask

    task automatic test_mask();
        reset_dut();
        i_data[0*DW +: DW] = 8'h3C;
        i_enable = 4'b1110;
        i_req    = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if (o_busy !== 4'b1111 || o_we !== 1'b0) begin
                n_fail++; $display("[TB] FAIL mask_idle%0d got busy=%b we=%b want 1111/0", c, o_busy, o_we);
            end
        end
        i_enable = 4'b1111;
        tick();
        n_cmp++;
        if (o_busy !== 4'b1110 || o_grant_idx !== 2'd0) begin
            n_fail++; $display("[TB] FAIL mask_grant got busy=%b idx=%0d want 1110 idx=0", o_busy, o_grant_idx);
        end
        i_enable = 4'b0000;
        i_req    = 4'b0000;
        tick();
        n_cmp++;
        if (o_we !== 1'b1 || o_data !== 8'h3C) begin
            n_fail++; $display("[TB] FAIL mask_disable_after_grant got we=%b data=%h want we=1 data=3c", o_we, o_data);
        end
        i_enable = 4'b1111;
        tick();
    endtask

    task automatic test_reset_mid_write();
        reset_dut();
        i_data[1*DW +: DW] = 8'h99;
        i_req = 4'b0010;
        tick();
        i_req = 4'b0000;
        tick();
        n_cmp++;
        if (o_we !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_pre_we got %b want 1", o_we); end
        #2;
        i_reset_n = 1'b0;
        #1;
        n_cmp++;
        if (o_we !== 1'b0 || o_busy !== 4'b1111) begin
            n_fail++; $display("[TB] FAIL midrst_async got we=%b busy=%b want 0/1111", o_we, o_busy);
        end
        #1;
        i_reset_n = 1'b1;
        i_req = 4'b1111;
        tick();
        n_cmp++;
        if (o_busy !== 4'b1110 || o_grant_idx !== 2'd0) begin
            n_fail++; $display("[TB] FAIL midrst_restart got busy=%b idx=%0d want 1110 idx=0", o_busy, o_grant_idx);
        end
        i_req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        i_reset_n = 1'b0;
        i_data    = '0;
        i_req     = '0;
        i_enable  = '1;
        i_full    = 1'b0;
        #12;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_mask();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
